// File: rtl/qmult_pkg.sv
// Shared definitions for the sign-magnitude Q-format multipliers:
// control states, iteration count and saturation magnitude.
package qmult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } qm_state_e;

   localparam logic [63:0] QM_ALL_ONES = '1;

   // Number of K-bit multiplicand digits needed to cover the N-1 magnitude bits.
   function automatic int qm_iters(input int n, input int k);
      return (n - 1 + k - 1) / k;
   endfunction

   // Largest representable magnitude, 2^(N-1)-1, right-aligned in 64 bits.
   function automatic logic [63:0] qm_sat_mag(input int n);
      return QM_ALL_ONES >> (65 - n);
   endfunction

endpackage

// File: rtl/qmult_finalize.sv
// Turns a full-width magnitude product into a Q-format sign-magnitude word:
// optional round-half-up, overflow detect, saturate/wrap, negative-zero removal.
module qmult_finalize #(
   parameter int N        = 32,
   parameter int Q        = 15,
   parameter int SATURATE = 1
) (
   input  logic [2*N-3:0] prod_i,
   input  logic           round_i,
   input  logic           sign_i,
   output logic [N-1:0]   result_o,
   output logic           overflow_o
);
   import qmult_pkg::*;

   localparam logic [63:0]  SAT_W   = qm_sat_mag(N);
   localparam logic [N-2:0] SAT_MAG = SAT_W[N-2:0];

   logic [N-1:0] sum;
   logic [N-2:0] mag;
   logic         hi_nz;
   logic         ovf;

   always_comb begin
      // One spare bit on top catches the carry out of the rounding increment.
      sum   = {1'b0, prod_i[N-2+Q:Q]} + {{(N-1){1'b0}}, round_i & prod_i[Q-1]};
      hi_nz = |prod_i[2*N-3:N-1+Q];
      ovf   = hi_nz | sum[N-1];
      mag   = sum[N-2:0];
      if (ovf && (SATURATE != 0)) mag = SAT_MAG;
      result_o   = {sign_i & (|mag), mag};
      overflow_o = ovf;
   end

   generate
      if (Q > 1) begin : g_lo
         logic unused_lo;
         assign unused_lo = ^prod_i[Q-2:0];
      end
   endgenerate

endmodule

// File: rtl/qmult_serial.sv
// Sequential sign-magnitude Q-format multiplier retiring K multiplicand bits
// per cycle, with valid/ready handshakes on both sides.
module qmult_serial #(
   parameter int N        = 32,
   parameter int Q        = 15,
   parameter int K        = 1,
   parameter int SATURATE = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_multiplicand,
   input  logic [N-1:0] i_multiplier,
   input  logic         i_round,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_result,
   output logic         o_overflow
);
   import qmult_pkg::*;

   localparam int C  = qm_iters(N, K);
   localparam int CW = $clog2(C + 1);
   localparam int AW = C * K;   // multiplicand padded to whole digits
   localparam int PW = 2 * N - 2;
   localparam logic [CW-1:0] LAST = CW'(C);

   qm_state_e     state_q;
   logic [AW-1:0] a_q;
   logic [PW-1:0] b_q;
   logic [PW-1:0] acc_q, acc_d;
   logic [PW-1:0] pp;
   logic [CW-1:0] cnt_q;
   logic          sign_q, round_q;
   logic [N-1:0]  result_q;
   logic          ovf_q, ready_q, valid_q;

   logic [AW-1:0] a_ext;
   logic [PW-1:0] b_ext;
   logic          op_zero;
   logic [N-1:0]  fin_result;
   logic          fin_ovf;

   assign a_ext   = AW'(i_multiplicand[N-2:0]);
   assign b_ext   = PW'(i_multiplier[N-2:0]);
   assign op_zero = ~|i_multiplicand[N-2:0] | ~|i_multiplier[N-2:0];

   // a_q shifts down and b_q shifts up each iteration, so the current digit
   // is always a_q[K-1:0] and b_q already carries the 2^(count*K) weight.
   always_comb begin
      pp = '0;
      for (int j = 0; j < K; j++) begin
         if (a_q[j]) pp = pp + (b_q << j);
      end
      acc_d = acc_q + pp;
   end

   qmult_finalize #(
      .N        (N),
      .Q        (Q),
      .SATURATE (SATURATE)
   ) u_fin (
      .prod_i     (acc_q),
      .round_i    (round_q),
      .sign_i     (sign_q),
      .result_o   (fin_result),
      .overflow_o (fin_ovf)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         round_q  <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  a_q     <= a_ext;
                  b_q     <= b_ext;
                  acc_q   <= '0;
                  sign_q  <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                  round_q <= i_round;
                  // A zero operand jumps the counter to the end: acc stays 0.
                  cnt_q   <= op_zero ? LAST : '0;
                  state_q <= BUSY;
                  ready_q <= 1'b0;
               end
            end
            BUSY: begin
               if (cnt_q == LAST) begin
                  result_q <= fin_result;
                  ovf_q    <= fin_ovf;
                  state_q  <= DONE;
                  valid_q  <= 1'b1;
               end else begin
                  acc_q <= acc_d;
                  a_q   <= a_q >> K;
                  b_q   <= b_q << K;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (i_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready    = ready_q;
   assign o_valid    = valid_q;
   assign o_result   = result_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_qmult_serial.sv
// Scoreboard bench: four multiplier configurations (K=1/2/4 saturating, K=4 wrapping)
// driven with directed vectors; a single monitor pops expectations and compares.
module tb_qmult_serial;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        rnd;
      logic [31:0] rs;
      logic        os;
      logic [31:0] rw;
      logic        ow;
      bit          zero;
      bit          hold;
   } vec_t;

   typedef struct {
      int          g;
      logic [31:0] res;
      logic        ovf;
      int          lat;
      bit          hold;
      int          stamp;
   } exp_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        rst_n  [4];
   logic        vld_i  [4];
   logic [31:0] a_i    [4];
   logic [31:0] b_i    [4];
   logic        rnd_i  [4];
   logic        rdy_i  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
   logic        ready_o[4];
   logic        valid_o[4];
   logic [31:0] res_o  [4];
   logic        ovf_o  [4];

   int          idle_req[4] = '{0, 0, 0, 0};
   int          idle_ack[4] = '{0, 0, 0, 0};
   bit          seen    [4] = '{0, 0, 0, 0};
   int          hold_cnt[4] = '{0, 0, 0, 0};
   logic [31:0] held_res[4];
   logic        held_ovf[4];
   int          wd = 0;
   int          lat_tab [4] = '{32, 17, 9, 9};

   exp_t        exp_q[$];
   vec_t        vq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      qmult_serial #(
         .N        (32),
         .Q        (15),
         .K        ((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
         .SATURATE ((g == 3) ? 0 : 1)
      ) u_dut (
         .i_clk          (clk),
         .i_rst_n        (rst_n[g]),
         .i_valid        (vld_i[g]),
         .o_ready        (ready_o[g]),
         .i_multiplicand (a_i[g]),
         .i_multiplier   (b_i[g]),
         .i_round        (rnd_i[g]),
         .o_valid        (valid_o[g]),
         .i_ready        (rdy_i[g]),
         .o_result       (res_o[g]),
         .o_overflow     (ovf_o[g])
      );
   end

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cfg%0d got %h want %h (t=%0t)", nm, g, act, want, $time);
      end
   endtask

   // Monitor: sole owner of i_ready and of the check counters.
   always @(negedge clk) begin
      exp_t e;
      for (int g = 0; g < 4; g++) begin
         if (idle_req[g] != idle_ack[g]) begin
            idle_ack[g] = idle_req[g];
            chk("rst_ready", g, 32'(ready_o[g]), 32'd1);
            chk("rst_valid", g, 32'(valid_o[g]), 32'd0);
            chk("rst_result", g, res_o[g], 32'd0);
            chk("rst_ovf", g, 32'(ovf_o[g]), 32'd0);
         end
         if (hold_cnt[g] > 0) begin
            chk("hold_result", g, res_o[g], held_res[g]);
            chk("hold_ovf", g, 32'(ovf_o[g]), 32'(held_ovf[g]));
            chk("hold_valid", g, 32'(valid_o[g]), 32'd1);
            chk("hold_ready", g, 32'(ready_o[g]), 32'd0);
            hold_cnt[g]--;
            if (hold_cnt[g] == 0) rdy_i[g] = 1'b1;
         end else if (valid_o[g] === 1'b1 && !seen[g]) begin
            seen[g] = 1'b1;
            if (exp_q.size() != 0 && exp_q[0].g == g) begin
               e  = exp_q.pop_front();
               wd = 0;
               chk("result", g, res_o[g], e.res);
               chk("ovf", g, 32'(ovf_o[g]), 32'(e.ovf));
               chk("latency", g, 32'(cyc - e.stamp), 32'(e.lat));
               if (e.hold) begin
                  hold_cnt[g] = 10;
                  held_res[g] = res_o[g];
                  held_ovf[g] = ovf_o[g];
                  rdy_i[g]    = 1'b0;
               end
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid cfg%0d got result %h want no output", g, res_o[g]);
            end
         end else if (valid_o[g] !== 1'b1) begin
            seen[g] = 1'b0;
         end
      end
      if (exp_q.size() != 0) begin
         wd++;
         if (wd > 100) begin
            checks++;
            errors++;
            $display("FAIL timeout cfg%0d got no o_valid want result %h", exp_q[0].g, exp_q[0].res);
            void'(exp_q.pop_front());
            wd = 0;
         end
      end else begin
         wd = 0;
      end
   end

   task automatic issue(input int g, input vec_t v, input bit push);
      exp_t e;
      int   n;
      n = 0;
      while (ready_o[g] !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      vld_i[g] = 1'b1;
      a_i[g]   = v.a;
      b_i[g]   = v.b;
      rnd_i[g] = v.rnd;
      @(posedge clk); #1;
      // Scramble inputs right after accept; the product must not notice.
      vld_i[g] = 1'b0;
      a_i[g]   = $urandom;
      b_i[g]   = $urandom;
      rnd_i[g] = 1'($urandom);
      if (push) begin
         e.g     = g;
         e.res   = (g == 3) ? v.rw : v.rs;
         e.ovf   = (g == 3) ? v.ow : v.os;
         e.lat   = v.zero ? 1 : lat_tab[g];
         e.hold  = v.hold;
         e.stamp = cyc;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      int n;
      //                  a             b             rnd   sat res      ovf   wrap res     ovf   zero hold
      vq.push_back('{32'h0000C000, 32'h00010000, 1'b0, 32'h00018000, 1'b0, 32'h00018000, 1'b0, 0, 0});
      vq.push_back('{32'h8000C000, 32'h00010000, 1'b0, 32'h80018000, 1'b0, 32'h80018000, 1'b0, 0, 0});
      vq.push_back('{32'h00018000, 32'h80008000, 1'b0, 32'h80018000, 1'b0, 32'h80018000, 1'b0, 0, 0});
      vq.push_back('{32'h00000001, 32'h00004000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 0, 0});
      vq.push_back('{32'h00000001, 32'h00004000, 1'b1, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 0, 0});
      vq.push_back('{32'h80000001, 32'h00004000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 0, 0});
      vq.push_back('{32'h80000001, 32'h00004000, 1'b1, 32'h80000001, 1'b0, 32'h80000001, 1'b0, 0, 0});
      vq.push_back('{32'h7FFFFFFF, 32'h00010000, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFE, 1'b1, 0, 0});
      vq.push_back('{32'h7FFFFFFF, 32'h00008000, 1'b1, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0, 0, 0});
      vq.push_back('{32'h80010001, 32'h3FFFC000, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 0, 0});
      vq.push_back('{32'h80010001, 32'h3FFFC000, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 0, 0});
      vq.push_back('{32'h80000000, 32'h00001234, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1, 1});
      vq.push_back('{32'h00001234, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1, 0});

      for (int g = 0; g < 4; g++) begin
         rst_n[g] = 1'b0;
         vld_i[g] = 1'b0;
         a_i[g]   = '0;
         b_i[g]   = '0;
         rnd_i[g] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         rst_n[g] = 1'b1;
         idle_req[g]++;
      end
      @(posedge clk); #1;

      for (int g = 0; g < 4; g++) begin
         foreach (vq[i]) issue(g, vq[i], 1'b1);
      end

      // Reset mid-BUSY: the in-flight product must vanish, the next one be correct.
      issue(0, vq[0], 1'b0);
      repeat (9) @(posedge clk);
      #1;
      rst_n[0] = 1'b0;
      @(posedge clk); #1;
      rst_n[0] = 1'b1;
      idle_req[0]++;
      issue(0, vq[1], 1'b1);
      issue(0, vq[10], 1'b1);

      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (15) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
